// File: rtl/bp_fe_fetch_ctrl.sv
// Front-end fetch controller: issues sequential fetches, tracks the two-stage
// fetch pipeline, replays icache misses and queues completed fetches for the backend.
module bp_fe_fetch_ctrl #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int fifo_els_p    = 4,
    parameter logic [vaddr_width_p-1:0] reset_pc_p = vaddr_width_p'(48'h0000_8000_0000)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,

    output logic [vaddr_width_p-1:0] mem_cmd_vaddr_o,
    output logic                     mem_cmd_v_o,
    input  logic                     mem_cmd_yumi_i,
    output logic                     mem_poison_o,

    input  logic                     mem_resp_v_i,
    input  logic [instr_width_p-1:0] mem_resp_data_i,
    input  logic                     mem_resp_itlb_miss_i,
    input  logic                     mem_resp_access_fault_i,
    input  logic                     mem_resp_page_fault_i,
    input  logic                     mem_resp_icache_miss_i,

    output logic [vaddr_width_p-1:0] fetch_pc_o,
    output logic [instr_width_p-1:0] fetch_instr_o,
    output logic [1:0]               fetch_exc_o,
    output logic                     fetch_v_o,
    input  logic                     fetch_yumi_i
);

    // state  | meaning
    // e_idle | out of reset, waiting for the first redirect
    // e_run  | issuing sequential fetches
    // e_wait | exception queued, waiting for a redirect
    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_run  = 2'd1,
        e_wait = 2'd2
    } state_e;

    localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w = $clog2(fifo_els_p + 1);
    localparam logic [vaddr_width_p-1:0] pc_incr = vaddr_width_p'(instr_width_p / 8);
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(fifo_els_p - 1);

    state_e state_r, state_n;
    logic [vaddr_width_p-1:0] next_pc_r, next_pc_n;

    logic                     s1_v_r, s2_v_r;
    logic [vaddr_width_p-1:0] s1_pc_r, s2_pc_r;

    logic [vaddr_width_p-1:0] pc_q    [fifo_els_p];
    logic [instr_width_p-1:0] instr_q [fifo_els_p];
    logic [1:0]               exc_q   [fifo_els_p];
    logic [ptr_w-1:0]         wptr_r, rptr_r;
    logic [cnt_w-1:0]         count_r;

    logic       resp_live, resp_exc, resp_miss, resp_clean;
    logic [1:0] resp_code;
    logic [cnt_w:0] in_flight;
    logic       accept, enq, deq;

    always_comb begin
        resp_live  = mem_resp_v_i & s2_v_r;
        resp_exc   = resp_live & (mem_resp_itlb_miss_i | mem_resp_access_fault_i
                                  | mem_resp_page_fault_i);
        resp_miss  = resp_live & ~resp_exc & mem_resp_icache_miss_i;
        resp_clean = resp_live & ~resp_exc & ~mem_resp_icache_miss_i;

        if (mem_resp_itlb_miss_i)         resp_code = 2'd1;
        else if (mem_resp_access_fault_i) resp_code = 2'd2;
        else if (mem_resp_page_fault_i)   resp_code = 2'd3;
        else                              resp_code = 2'd0;

        in_flight = (cnt_w+1)'(count_r) + (cnt_w+1)'(s1_v_r) + (cnt_w+1)'(s2_v_r);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_idle;
            next_pc_r <= reset_pc_p;
        end else begin
            state_r   <= state_n;
            next_pc_r <= next_pc_n;
        end
    end

    always_comb begin
        state_n         = state_r;
        next_pc_n       = next_pc_r;
        mem_poison_o    = redirect_v_i | resp_exc | resp_miss;
        mem_cmd_v_o     = 1'b0;
        mem_cmd_vaddr_o = next_pc_r;
        enq             = 1'b0;

        // Credit check counts fetches still in flight so the queue can never overflow
        if (state_r == e_run && !mem_poison_o && in_flight < (cnt_w+1)'(fifo_els_p))
            mem_cmd_v_o = 1'b1;
        accept = mem_cmd_v_o & mem_cmd_yumi_i;

        if (redirect_v_i) begin
            state_n   = e_run;
            next_pc_n = redirect_pc_i;
        end else begin
            enq = resp_exc | resp_clean;
            case (state_r)
                e_run: begin
                    if (resp_exc)
                        state_n = e_wait;
                    else if (resp_miss)
                        next_pc_n = s2_pc_r;
                    else if (accept)
                        next_pc_n = next_pc_r + pc_incr;
                end
                e_idle, e_wait: ;
                default: state_n = e_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_r  <= 1'b0;
            s2_v_r  <= 1'b0;
            s1_pc_r <= '0;
            s2_pc_r <= '0;
        end else begin
            s1_v_r  <= accept;
            s1_pc_r <= next_pc_r;
            s2_v_r  <= s1_v_r & ~mem_poison_o;
            s2_pc_r <= s1_pc_r;
        end
    end

    always_comb begin
        fetch_v_o     = (count_r != '0) & ~redirect_v_i;
        deq           = fetch_v_o & fetch_yumi_i;
        fetch_pc_o    = pc_q[rptr_r];
        fetch_instr_o = instr_q[rptr_r];
        fetch_exc_o   = exc_q[rptr_r];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < fifo_els_p; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                exc_q[i]   <= '0;
            end
        end else if (redirect_v_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) begin
                pc_q[wptr_r]    <= s2_pc_r;
                instr_q[wptr_r] <= mem_resp_data_i;
                exc_q[wptr_r]   <= resp_code;
                wptr_r          <= (wptr_r == ptr_last) ? '0 : wptr_r + 1'b1;
            end
            if (deq)
                rptr_r <= (rptr_r == ptr_last) ? '0 : rptr_r + 1'b1;
            count_r <= count_r + cnt_w'(enq) - cnt_w'(deq);
        end
    end

    resp_has_slot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_v_i |-> s2_v_r);

endmodule

// File: tb/tb_bp_fe_fetch_ctrl.sv
// Directed bench for bp_fe_fetch_ctrl with a small two-cycle mem-stage model.
module tb_bp_fe_fetch_ctrl;

    localparam int VW = 39;
    localparam logic [VW-1:0] NONE = '1;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          redirect_v_i;
    logic [VW-1:0] redirect_pc_i;
    logic [VW-1:0] mem_cmd_vaddr_o;
    logic          mem_cmd_v_o;
    logic          mem_cmd_yumi_i;
    logic          mem_poison_o;
    logic          mem_resp_v_i;
    logic [31:0]   mem_resp_data_i;
    logic          mem_resp_itlb_miss_i;
    logic          mem_resp_access_fault_i;
    logic          mem_resp_page_fault_i;
    logic          mem_resp_icache_miss_i;
    logic [VW-1:0] fetch_pc_o;
    logic [31:0]   fetch_instr_o;
    logic [1:0]    fetch_exc_o;
    logic          fetch_v_o;
    logic          fetch_yumi_i;

    bp_fe_fetch_ctrl dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .redirect_v_i(redirect_v_i), .redirect_pc_i(redirect_pc_i),
        .mem_cmd_vaddr_o(mem_cmd_vaddr_o), .mem_cmd_v_o(mem_cmd_v_o),
        .mem_cmd_yumi_i(mem_cmd_yumi_i), .mem_poison_o(mem_poison_o),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i),
        .mem_resp_itlb_miss_i(mem_resp_itlb_miss_i),
        .mem_resp_access_fault_i(mem_resp_access_fault_i),
        .mem_resp_page_fault_i(mem_resp_page_fault_i),
        .mem_resp_icache_miss_i(mem_resp_icache_miss_i),
        .fetch_pc_o(fetch_pc_o), .fetch_instr_o(fetch_instr_o),
        .fetch_exc_o(fetch_exc_o), .fetch_v_o(fetch_v_o), .fetch_yumi_i(fetch_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // mem-stage model: m1 = accepted last cycle, m2 = responding this cycle
    logic          m1_v = 1'b0, m2_v = 1'b0;
    logic [VW-1:0] m1_pc = '0, m2_pc = '0;
    logic [VW-1:0] miss_pc = NONE, itlb_pc = NONE, pf_pc = NONE;

    logic s_poison, s_fetch_v, s_cmd_v, acc;
    logic [VW-1:0] acc_pc;
    logic [VW-1:0] acc_log[$];
    logic [VW-1:0] got_pc[$];
    logic [1:0]    got_exc[$];
    int            poison_cnt;
    logic [VW-1:0] poison_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rv, input logic [VW-1:0] rpc);
        @(negedge clk_i);
        redirect_v_i            = rv;
        redirect_pc_i           = rpc;
        mem_resp_v_i            = m2_v;
        mem_resp_data_i         = 32'h13;
        mem_resp_itlb_miss_i    = m2_v && (m2_pc == itlb_pc);
        mem_resp_access_fault_i = 1'b0;
        mem_resp_page_fault_i   = m2_v && (m2_pc == pf_pc);
        mem_resp_icache_miss_i  = m2_v && (m2_pc == miss_pc);
        #1;
        s_poison  = mem_poison_o;
        s_fetch_v = fetch_v_o;
        s_cmd_v   = mem_cmd_v_o;
        acc       = mem_cmd_v_o & mem_cmd_yumi_i;
        acc_pc    = mem_cmd_vaddr_o;
        if (acc) acc_log.push_back(acc_pc);
        if (fetch_v_o && fetch_yumi_i) begin
            got_pc.push_back(fetch_pc_o);
            got_exc.push_back(fetch_exc_o);
        end
        if (mem_poison_o && !rv) begin
            poison_cnt++;
            poison_pc = m2_pc;
        end
        if (mem_resp_icache_miss_i && !rv) miss_pc = NONE;
        @(posedge clk_i);
        #1;
        m2_v  = m1_v & ~s_poison;
        m2_pc = m1_pc;
        m1_v  = acc;
        m1_pc = acc_pc;
        redirect_v_i = 1'b0;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        got_pc.delete();
        got_exc.delete();
        poison_cnt = 0;
        poison_pc  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n_i = 1'b0;
        redirect_v_i = 1'b0; redirect_pc_i = '0;
        mem_cmd_yumi_i = 1'b1; fetch_yumi_i = 1'b1;
        mem_resp_v_i = 1'b0; mem_resp_data_i = '0;
        mem_resp_itlb_miss_i = 1'b0; mem_resp_access_fault_i = 1'b0;
        mem_resp_page_fault_i = 1'b0; mem_resp_icache_miss_i = 1'b0;
        clear_logs();
        #12;
        chk("rst_cmd_v", mem_cmd_v_o, 0);
        chk("rst_poison", mem_poison_o, 0);
        chk("rst_fetch_v", fetch_v_o, 0);
        chk("rst_vaddr", mem_cmd_vaddr_o, 64'h80000000);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick(0, '0);
        tick(0, '0);
        chk("idle_no_cmd", s_cmd_v, 0);

        // clean sequential stream
        clear_logs();
        tick(1, 39'h1000);
        n = 0;
        while (!fetch_v_o && n < 10) begin
            tick(0, '0);
            n++;
        end
        chk("first_fetch_v_edges", n, 3);
        repeat (6) tick(0, '0);
        chk("a_pc0", got_pc[0], 64'h1000);
        chk("a_pc1", got_pc[1], 64'h1004);
        chk("a_pc2", got_pc[2], 64'h1008);
        chk("a_exc", got_exc[0] | got_exc[1] | got_exc[2], 0);

        // icache miss on 0x1004 replays it
        clear_logs();
        miss_pc = 39'h1004;
        tick(1, 39'h1000);
        poison_cnt = 0;
        repeat (12) tick(0, '0);
        chk("b_poison_cnt", poison_cnt, 1);
        chk("b_poison_pc", poison_pc, 64'h1004);
        chk("b_replay_cmd", acc_log[3], 64'h1004);
        chk("b_pc0", got_pc[0], 64'h1000);
        chk("b_pc1", got_pc[1], 64'h1004);
        chk("b_pc2", got_pc[2], 64'h1008);
        chk("b_pc3", got_pc[3], 64'h100c);

        // ITLB miss + page fault together: single exception entry, then wait
        clear_logs();
        itlb_pc = 39'h2000;
        pf_pc   = 39'h2000;
        tick(1, 39'h2000);
        repeat (3) tick(0, '0);
        n = 0;
        repeat (6) begin
            tick(0, '0);
            if (s_cmd_v) n++;
        end
        chk("c_no_issue_in_wait", n, 0);
        chk("c_entries", got_pc.size(), 1);
        chk("c_pc", got_pc[0], 64'h2000);
        chk("c_exc", got_exc[0], 1);
        itlb_pc = NONE;
        pf_pc   = NONE;
        tick(1, 39'h3000);
        repeat (6) tick(0, '0);
        chk("c_resume_pc", got_pc[1], 64'h3000);
        chk("c_resume_exc", got_exc[1], 0);

        // consumer stall: credit limit stops issue at 4
        clear_logs();
        fetch_yumi_i = 1'b0;
        tick(1, 39'h4000);
        repeat (8) tick(0, '0);
        chk("d_accepts", acc_log.size(), 4);
        chk("d_cmd_v_full", s_cmd_v, 0);
        chk("d_head_pc", fetch_pc_o, 64'h4000);
        fetch_yumi_i = 1'b1;
        repeat (8) tick(0, '0);
        chk("d_pc0", got_pc[0], 64'h4000);
        chk("d_pc1", got_pc[1], 64'h4004);
        chk("d_pc2", got_pc[2], 64'h4008);
        chk("d_pc3", got_pc[3], 64'h400c);
        chk("d_pc4", got_pc[4], 64'h4010);

        // redirect coincident with a clean response, two entries queued
        clear_logs();
        fetch_yumi_i = 1'b0;
        tick(1, 39'h1008);
        repeat (4) tick(0, '0);
        chk("e_head_before", fetch_pc_o, 64'h1008);
        tick(1, 39'h5000);
        chk("e_poison", s_poison, 1);
        chk("e_fetch_v_redirect", s_fetch_v, 0);
        chk("e_cmd_v_redirect", s_cmd_v, 0);
        chk("e_empty_after", fetch_v_o, 0);
        fetch_yumi_i = 1'b1;
        repeat (6) tick(0, '0);
        chk("e_pc0", got_pc[0], 64'h5000);
        chk("e_pc1", got_pc[1], 64'h5004);

        // mem-stage stall holds the command
        clear_logs();
        mem_cmd_yumi_i = 1'b0;
        tick(1, 39'h6000);
        repeat (3) begin
            tick(0, '0);
            chk("g_hold_v", s_cmd_v, 1);
            chk("g_hold_vaddr", acc_pc, 64'h6000);
        end
        mem_cmd_yumi_i = 1'b1;
        repeat (2) tick(0, '0);
        chk("g_acc0", acc_log[0], 64'h6000);
        chk("g_acc1", acc_log[1], 64'h6004);

        // address wrap, then asynchronous reset mid-stream
        clear_logs();
        tick(1, 39'h7F_FFFF_FFFC);
        repeat (6) tick(0, '0);
        chk("f_pc0", got_pc[0], 64'h7F_FFFF_FFFC);
        chk("f_pc1", got_pc[1], 64'h0);
        chk("f_running", s_cmd_v, 1);
        @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        chk("f_async_cmd_v", mem_cmd_v_o, 0);
        chk("f_async_poison", mem_poison_o, 0);
        chk("f_async_fetch_v", fetch_v_o, 0);
        m1_v = 1'b0;
        m2_v = 1'b0;
        mem_resp_v_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        n = 0;
        repeat (3) begin
            tick(0, '0);
            if (s_cmd_v) n++;
        end
        chk("f_idle_after_reset", n, 0);
        chk("f_vaddr_after_reset", mem_cmd_vaddr_o, 64'h80000000);
        chk("f_fetch_v_after_reset", fetch_v_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_fetch_ctrl.md
Name: bp_fe_fetch_ctrl

Overview:
Front-end fetch controller that sits directly upstream and downstream of the FE memory stage. It generates sequential fetch commands and tracks the 2-cycle in-flight fetch pipeline. It consumes fetch responses, replays on icache miss, and raises exceptions on ITLB miss or faults. Completed fetches go into a small credit-protected queue that feeds the FE-to-BE instruction interface.

Parameters:
vaddr_width_p, 39, virtual address width
instr_width_p, 32, instruction width; PC increment is instr_width_p/8 bytes
fifo_els_p, 4, output queue depth (at least 2)
reset_pc_p, 0x0000_8000_0000 truncated to vaddr_width_p, PC used if the first redirect is absent (unused until redirect; see Behaviour)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
redirect_v_i  in  1  backend redirect/flush strobe
redirect_pc_i  in  vaddr_width_p  redirect target
mem_cmd_vaddr_o  out  vaddr_width_p  fetch vaddr (op is always fetch)
mem_cmd_v_o  out  1  fetch command valid
mem_cmd_yumi_i  in  1  mem stage accepted command this cycle
mem_poison_o  out  1  kills the fetch accepted in the previous cycle
mem_resp_v_i  in  1  fetch response valid (2 cycles after accept)
mem_resp_data_i  in  instr_width_p  instruction
mem_resp_itlb_miss_i  in  1  ITLB miss
mem_resp_access_fault_i  in  1  access fault
mem_resp_page_fault_i  in  1  page fault
mem_resp_icache_miss_i  in  1  icache miss
fetch_pc_o  out  vaddr_width_p  queue head PC
fetch_instr_o  out  instr_width_p  queue head instruction
fetch_exc_o  out  2  0 none, 1 itlb miss, 2 access fault, 3 page fault
fetch_v_o  out  1  queue head valid
fetch_yumi_i  in  1  consumer dequeues head

Behaviour:
- Async active-low reset. Values during reset:
  - state = e_idle; mem_cmd_v_o = 0, mem_poison_o = 0, fetch_v_o = 0.
  - queue empty; s1_v = s2_v = 0; next_pc = reset_pc_p.
- States:
  - e_idle: no issue. Redirect goes to e_run.
  - e_run: issue sequential fetches.
  - e_wait: exception enqueued. No issue. Redirect goes to e_run.
- Pipeline tracking:
  - An accept sets s1_v and s1_pc.
  - Each cycle, s2 <= s1 & ~mem_poison_o, and s1 <= the new accept.
  - A response is expected iff s2_v. A mem_resp_v_i without s2_v is an error (assertion).
- Issue rule: mem_cmd_v_o = (state == e_run) & ~mem_poison_o & (count + s1_v + s2_v < fifo_els_p). mem_cmd_vaddr_o = next_pc.
- On accept (mem_cmd_v_o & mem_cmd_yumi_i), next_pc += instr_width_p/8, modulo 2^vaddr_width_p (wraps).
- Response handling when mem_resp_v_i & s2_v & ~redirect_v_i, with priority itlb_miss > access_fault > page_fault > icache_miss:
  - Exception: enqueue {s2_pc, data, code}, assert mem_poison_o, go to e_wait.
  - icache miss: no enqueue, assert mem_poison_o, next_pc = s2_pc (replay), stay in e_run.
  - Clean response: enqueue {s2_pc, data, 0}.
- Redirect (highest priority):
  - mem_poison_o = 1.
  - The response arriving in the same cycle is dropped.
  - Queue cleared at the clock edge; fetch_v_o forced to 0 in the redirect cycle.
  - next_pc = redirect_pc_i; state = e_run.
  - No command is issued in the redirect cycle.
- mem_poison_o = redirect_v_i | (mem_resp_v_i & s2_v & (any miss or fault)). Combinational, same cycle as the cause.
- Queue:
  - FIFO of fifo_els_p entries with wrapping read/write pointers and a count.
  - Simultaneous enqueue and dequeue when full or empty is legal, because the credit rule guarantees enqueue never overflows.
  - fetch_v_o = (count != 0) & ~redirect_v_i. Dequeue when fetch_v_o & fetch_yumi_i.
- The mem stage stalling (yumi low, e.g. during icache refill) holds next_pc and mem_cmd_v_o steady.

Test Plan:
- Reset deasserted, redirect to 0x1000, yumi always 1, clean responses with data 0x13 → queue entries with PCs 0x1000, 0x1004, 0x1008 in order, exc = 0; first fetch_v_o 3 cycles after the redirect cycle.
- Icache miss on 0x1004 → poison asserted that cycle; the 0x1008 fetch is dropped; next command is 0x1004 again; queue order stays 0x1000, 0x1004, 0x1008 with no duplicates.
- ITLB miss and page fault together on 0x2000 → exactly one entry {0x2000, exc = 1}; mem_cmd_v_o stays 0 until a redirect to 0x3000, then fetches resume at 0x3000.
- Consumer holds fetch_yumi_i = 0 with fifo_els_p = 4 → at most 4 entries, mem_cmd_v_o drops once count + in-flight reaches 4; releasing yumi drains all entries in order with no loss.
- Redirect to 0x5000 in the same cycle a clean response for 0x1010 arrives with 2 entries queued → poison = 1, fetch_v_o = 0 that cycle, queue empty afterwards; first new entry is 0x5000.
- Redirect to 0x7F_FFFF_FFFC (vaddr_width_p = 39) → entries 0x7F_FFFF_FFFC then 0x0; reset_n_i pulsed mid-stream → all outputs 0 immediately (asynchronous), and state is e_idle after release.
